// File: rtl/mac_learn_scheduler.sv
// Buffers one learn request per ingress port and feeds the MAC table's single
// learn port round-robin, with periodic aging commands taking priority.
module mac_learn_scheduler #(
    parameter int NUM_PORTS   = 8,
    parameter int MAC_W       = 48,
    parameter int NUM_ENTRIES = 1024,
    parameter int AGE_PERIOD  = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           learn_valid_i,
    input  logic [NUM_PORTS*MAC_W-1:0]     learn_mac_i,
    output logic [NUM_PORTS-1:0]           learn_ready_o,
    input  logic                           tbl_busy_i,
    output logic                           tbl_learn_en_o,
    output logic [MAC_W-1:0]               tbl_learn_mac_o,
    output logic [$clog2(NUM_PORTS)-1:0]   tbl_learn_port_o,
    output logic                           tbl_age_en_o,
    output logic [$clog2(NUM_ENTRIES)-1:0] tbl_age_index_o
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int CW = $clog2(AGE_PERIOD);
    localparam logic [CW-1:0] AGE_RELOAD = CW'(AGE_PERIOD - 1);
    localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0] pend_reg;
    logic [NUM_PORTS-1:0] pend_next;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] grant_clear;
    logic [MAC_W-1:0]     mac_buf_reg [NUM_PORTS];
    logic [PW-1:0]        rr_ptr_reg;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        cand;
    logic                 grant_any;
    logic [CW-1:0]        age_cnt_reg;
    logic [IW-1:0]        age_idx_reg;
    logic                 age_pend_reg;
    logic                 age_expire;
    logic                 issue_age;
    logic                 issue_learn;

    logic                 learn_en_reg;
    logic [MAC_W-1:0]     learn_mac_reg;
    logic [PW-1:0]        learn_port_reg;
    logic                 age_en_reg;
    logic [IW-1:0]        age_index_reg;

    // First pending port at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PW'((int'(rr_ptr_reg) + i) % NUM_PORTS);
            if (!grant_any && pend_reg[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign age_expire  = (age_cnt_reg == '0);
    assign issue_age   = !tbl_busy_i && age_pend_reg;
    assign issue_learn = !tbl_busy_i && !age_pend_reg && grant_any;

    // A port is only accepted while its buffer is empty, so accept and
    // grant never touch the same bit on one edge.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign accept[gi]      = learn_valid_i[gi] && !pend_reg[gi];
        assign grant_clear[gi] = issue_learn && (grant_idx == PW'(gi));
    end

    assign pend_next = (pend_reg & ~grant_clear) | accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_reg <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                mac_buf_reg[p] <= '0;
            end
            rr_ptr_reg     <= '0;
            age_cnt_reg    <= AGE_RELOAD;
            age_idx_reg    <= '0;
            age_pend_reg   <= 1'b0;
            learn_en_reg   <= 1'b0;
            learn_mac_reg  <= '0;
            learn_port_reg <= '0;
            age_en_reg     <= 1'b0;
            age_index_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (accept[p]) begin
                    mac_buf_reg[p] <= learn_mac_i[p*MAC_W +: MAC_W];
                end
            end
            age_cnt_reg <= age_expire ? AGE_RELOAD : age_cnt_reg - CW'(1);
            // Saturating flag: an expiry on the issuing edge keeps it set.
            age_pend_reg <= age_expire || (age_pend_reg && !issue_age);
            learn_en_reg <= issue_learn;
            age_en_reg   <= issue_age;
            if (issue_learn) begin
                learn_mac_reg  <= mac_buf_reg[grant_idx];
                learn_port_reg <= grant_idx;
                rr_ptr_reg     <= (grant_idx == LAST_PORT) ? '0 : grant_idx + PW'(1);
            end
            if (issue_age) begin
                age_index_reg <= age_idx_reg;
                age_idx_reg   <= age_idx_reg + IW'(1);
            end
        end
    end

    assign learn_ready_o    = ~pend_reg;
    assign tbl_learn_en_o   = learn_en_reg;
    assign tbl_learn_mac_o  = learn_mac_reg;
    assign tbl_learn_port_o = learn_port_reg;
    assign tbl_age_en_o     = age_en_reg;
    assign tbl_age_index_o  = age_index_reg;

endmodule

// File: tb/tb_mac_learn_scheduler.sv
// Bench for mac_learn_scheduler: a learn-path instance with aging out of reach,
// a fast-aging instance, and a saturation instance with a two-cycle period.
module tb_mac_learn_scheduler;
    localparam int NP = 8;
    localparam int MW = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [NP-1:0]    valid_a, ready_a, valid_b, ready_b, valid_c, ready_c;
    logic [NP*MW-1:0] mac_a, mac_b, mac_c;
    logic             busy_a, busy_b, busy_c;
    logic             learn_en_a, learn_en_b, learn_en_c;
    logic             age_en_a, age_en_b, age_en_c;
    logic [MW-1:0]    learn_mac_a, learn_mac_b, learn_mac_c;
    logic [2:0]       learn_port_a, learn_port_b, learn_port_c;
    logic [9:0]       age_index_a, age_index_c;
    logic [1:0]       age_index_b;

    mac_learn_scheduler #(.NUM_PORTS(NP), .MAC_W(MW), .NUM_ENTRIES(1024), .AGE_PERIOD(4096)) dut_a (
        .clk(clk), .reset(reset), .learn_valid_i(valid_a), .learn_mac_i(mac_a),
        .learn_ready_o(ready_a), .tbl_busy_i(busy_a), .tbl_learn_en_o(learn_en_a),
        .tbl_learn_mac_o(learn_mac_a), .tbl_learn_port_o(learn_port_a),
        .tbl_age_en_o(age_en_a), .tbl_age_index_o(age_index_a));

    mac_learn_scheduler #(.NUM_PORTS(NP), .MAC_W(MW), .NUM_ENTRIES(4), .AGE_PERIOD(4)) dut_b (
        .clk(clk), .reset(reset), .learn_valid_i(valid_b), .learn_mac_i(mac_b),
        .learn_ready_o(ready_b), .tbl_busy_i(busy_b), .tbl_learn_en_o(learn_en_b),
        .tbl_learn_mac_o(learn_mac_b), .tbl_learn_port_o(learn_port_b),
        .tbl_age_en_o(age_en_b), .tbl_age_index_o(age_index_b));

    mac_learn_scheduler #(.NUM_PORTS(NP), .MAC_W(MW), .NUM_ENTRIES(1024), .AGE_PERIOD(2)) dut_c (
        .clk(clk), .reset(reset), .learn_valid_i(valid_c), .learn_mac_i(mac_c),
        .learn_ready_o(ready_c), .tbl_busy_i(busy_c), .tbl_learn_en_o(learn_en_c),
        .tbl_learn_mac_o(learn_mac_c), .tbl_learn_port_o(learn_port_c),
        .tbl_age_en_o(age_en_c), .tbl_age_index_o(age_index_c));

    typedef struct packed {
        logic [2:0]    port;
        logic [MW-1:0] mac;
    } learn_t;

    // order: nibble i holds the port of the i-th expected grant.
    typedef struct packed {
        logic [7:0]  mask;
        logic [3:0]  count;
        logic [31:0] order;
    } vec_t;

    learn_t learn_q[$];
    vec_t   vecs[5];
    int     checks = 0;
    int     errors = 0;
    learn_t e;
    learn_t got;
    logic   exp_age;
    int     exp_idx;
    int     exp_port;

    function automatic logic [MW-1:0] mac_of(input logic [15:0] tag, input int p);
        return {tag, 32'(p)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [7:0] mask, input logic [15:0] tag);
        valid_a = mask;
        for (int p = 0; p < NP; p++) mac_a[p*MW +: MW] = mac_of(tag, p);
    endtask

    task automatic push(input int port, input logic [MW-1:0] mac);
        learn_t t;
        t.port = 3'(port);
        t.mac  = mac;
        learn_q.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard for the learn-path instance.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && learn_en_a === 1'b1) begin
                if (learn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_learn: got port %0d expected none", learn_port_a);
                end else begin
                    got = learn_q.pop_front();
                    check("a_learn_port", 64'(learn_port_a), 64'(got.port));
                    check("a_learn_mac", 64'(learn_mac_a), 64'(got.mac));
                    $display("learn port %0d mac %012h", learn_port_a, learn_mac_a);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hFF, 4'd8, 32'h7654_3210};
        vecs[1] = '{8'h24, 4'd2, 32'h0000_0052};
        vecs[2] = '{8'h02, 4'd1, 32'h0000_0001};
        vecs[3] = '{8'hFF, 4'd8, 32'h1076_5432};
        vecs[4] = '{8'hC0, 4'd2, 32'h0000_0076};

        reset = 1'b1;
        valid_a = '0; valid_b = '0; valid_c = '0;
        mac_a = '0; mac_b = '0; mac_c = '0;
        busy_a = 1'b0; busy_b = 1'b0; busy_c = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_learn_en", 64'({learn_en_a, learn_en_b, learn_en_c}), 64'(0));
        check("rst_age_en", 64'({age_en_a, age_en_b, age_en_c}), 64'(0));
        check("rst_mac", 64'(learn_mac_a | learn_mac_b | learn_mac_c), 64'(0));
        check("rst_port", 64'(learn_port_a | learn_port_b | learn_port_c), 64'(0));
        check("rst_index", 64'(age_index_a | age_index_c | 10'(age_index_b)), 64'(0));
        check("rst_ready", 64'({ready_a, ready_b, ready_c}), 64'(24'hFFFFFF));
        @(negedge clk);
        reset = 1'b0;

        // Round-robin bursts, all accepted on one edge and drained back to back.
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            drive_a(vecs[r].mask, 16'(r + 1));
            for (int i = 0; i < int'(vecs[r].count); i++) begin
                e.port = vecs[r].order[i*4 +: 3];
                e.mac  = mac_of(16'(r + 1), int'(e.port));
                learn_q.push_back(e);
            end
            @(negedge clk);
            valid_a = '0;
            repeat (int'(vecs[r].count)) @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("a_row%0d_drained", r), 64'(learn_q.size()), 64'(0));
        end

        // Back-pressure: ports 0 and 6 held through ten stalled cycles.
        @(negedge clk);
        busy_a = 1'b1;
        drive_a(8'h41, 16'h00B9);
        push(0, mac_of(16'h00B9, 0));
        push(6, mac_of(16'h00B9, 6));
        @(negedge clk);
        valid_a = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("a_busy_no_learn", 64'(learn_en_a), 64'(0));
            check("a_busy_ready", 64'({ready_a[6], ready_a[0]}), 64'(0));
        end
        @(negedge clk);
        busy_a = 1'b0;
        @(posedge clk);
        #1;
        check("a_bp_first_en", 64'(learn_en_a), 64'(1));
        check("a_bp_first_port", 64'(learn_port_a), 64'(0));
        @(posedge clk);
        #1;
        check("a_bp_second_en", 64'(learn_en_a), 64'(1));
        check("a_bp_second_port", 64'(learn_port_a), 64'(6));
        @(negedge clk);
        #1;
        check("a_bp_drained", 64'(learn_q.size()), 64'(0));

        // Single request: latency and ready timing.
        @(negedge clk);
        valid_a = 8'h08;
        mac_a[3*MW +: MW] = 48'h0011_2233_4455;
        push(3, 48'h0011_2233_4455);
        @(posedge clk);
        #1;
        check("a_single_ready_low", 64'(ready_a[3]), 64'(0));
        check("a_single_not_yet", 64'(learn_en_a), 64'(0));
        @(negedge clk);
        valid_a = '0;
        @(posedge clk);
        #1;
        check("a_single_en", 64'(learn_en_a), 64'(1));
        check("a_single_port", 64'(learn_port_a), 64'(3));
        check("a_single_mac", 64'(learn_mac_a), 64'(48'h0011_2233_4455));
        check("a_single_ready_back", 64'(ready_a[3]), 64'(1));
        @(posedge clk);
        #1;
        check("a_single_one_cycle", 64'(learn_en_a), 64'(0));
        @(negedge clk);
        #1;
        check("a_queue_empty", 64'(learn_q.size()), 64'(0));

        // Fast aging with every port requesting continuously.
        do_reset();
        valid_b = '1;
        for (int p = 0; p < NP; p++) mac_b[p*MW +: MW] = mac_of(16'hB000, p);
        exp_idx  = 0;
        exp_port = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            exp_age = (c >= 5) && ((c - 5) % 4 == 0);
            check($sformatf("b_age_en_c%0d", c), 64'(age_en_b), 64'(exp_age));
            check($sformatf("b_learn_en_c%0d", c), 64'(learn_en_b), 64'((c >= 2) && !exp_age));
            if (exp_age) begin
                check("b_age_index", 64'(age_index_b), 64'(exp_idx));
                exp_idx = (exp_idx + 1) % 4;
            end else if (c >= 2) begin
                check("b_learn_port", 64'(learn_port_b), 64'(exp_port));
                check("b_learn_mac", 64'(learn_mac_b), 64'(mac_of(16'hB000, exp_port)));
                exp_port = (exp_port + 1) % NP;
            end
        end

        // Reset mid-cycle with buffered requests and an age command pending.
        @(negedge clk);
        valid_b = '0;
        repeat (16) @(negedge clk);
        busy_b  = 1'b1;
        valid_b = 8'h0F;
        @(negedge clk);
        valid_b = '0;
        repeat (5) @(negedge clk);
        check("b_ready_before_reset", 64'(ready_b), 64'(8'hF0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("b_midrst_en", 64'({learn_en_b, age_en_b}), 64'(0));
        check("b_midrst_mac", 64'(learn_mac_b), 64'(0));
        check("b_midrst_port_index", 64'({learn_port_b, age_index_b}), 64'(0));
        check("b_midrst_ready", 64'(ready_b), 64'(8'hFF));
        @(negedge clk);
        reset  = 1'b0;
        busy_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("b_post_rst_learn_c%0d", c), 64'(learn_en_b), 64'(0));
            check($sformatf("b_post_rst_age_c%0d", c), 64'(age_en_b), 64'(c == 5));
            if (c == 5) check("b_post_rst_index", 64'(age_index_b), 64'(0));
        end

        // Aging saturation: six busy cycles collapse into a single age command.
        busy_c = 1'b1;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            exp_age = (c == 7) || (c == 9) || (c == 11);
            check($sformatf("c_age_en_c%0d", c), 64'(age_en_c), 64'(exp_age));
            check("c_no_learn", 64'(learn_en_c), 64'(0));
            if (exp_age) check($sformatf("c_age_index_c%0d", c), 64'(age_index_c), 64'((c - 7) / 2));
            if (c == 6) busy_c = 1'b0;
        end

        check("a_queue_empty_end", 64'(learn_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
